ax_err_monitor: RTL and testbench
=================================

Name: ax_err_monitor

Overview:
- Sequential error-measurement stage that sits directly downstream of any approximate adder in the adder library.
- Consumes the adder operands A, B and the adder's approximate sum, and recomputes the exact sum internally.
- Accumulates error statistics over a fixed window of samples: sum of absolute error, maximum absolute error and count of erroneous samples.
- Presents the statistics through a valid/ready result interface for design-space exploration runs.

Parameters:
- BIT_WIDTH, 8: operand width; must match the monitored adder's BIT_WIDTH.
- WINDOW_LOG2, 8: window length is 2^WINDOW_LOG2 accepted samples; legal range is 1..16.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that opens a measurement window; honoured only in IDLE.
- in_valid  input  1  sample present on a/b/ax_out.
- in_ready  output  1  monitor accepts a sample this cycle.
- a  input  BIT_WIDTH  adder operand A.
- b  input  BIT_WIDTH  adder operand B.
- ax_out  input  BIT_WIDTH+1  approximate sum from the adder under test.
- res_valid  output  1  statistics are final and stable.
- res_ready  input  1  consumer takes the statistics.
- sum_abs_err  output  BIT_WIDTH+1+WINDOW_LOG2  sum of |exact - ax_out| over the window.
- max_abs_err  output  BIT_WIDTH+1  largest |exact - ax_out| in the window.
- err_count  output  WINDOW_LOG2+1  number of samples with nonzero error.
- busy  output  1  high in RUN or DRAIN.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, res_valid=0, busy=0; sum_abs_err, max_abs_err, err_count, sample counter and pipeline valids all 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 clears all accumulators and the sample counter, then moves to RUN.
- RUN:
  - in_ready=1; a sample is accepted on any edge with in_valid&in_ready.
  - The acceptance that makes the accepted count equal 2^WINDOW_LOG2 moves the FSM to DRAIN; no further samples are taken.
  - in_valid gaps are allowed and are not counted.
  - start is ignored.
- Pipeline:
  - Stage 1 (acceptance edge T): register exact = a+b (BIT_WIDTH+1 bits, zero-extended, never overflows), ax_out, and v1.
  - Stage 2 (edge T+1): d = exact>=ax ? exact-ax : ax-exact, registered with v2. The absolute value is needed because ax may exceed exact (trunc1/eta1 style adders).
  - Accumulate (edge T+2): if v2, add d to sum_abs_err, set max_abs_err = max(max_abs_err, d), and increment err_count when d != 0.
- DRAIN:
  - in_ready=0.
  - Moves to DONE on the edge where the final accumulation occurs, i.e. the last sample accepted at edge T gives DONE after edge T+2.
- DONE:
  - res_valid=1; all three result outputs are held stable until handshake.
  - res_valid&res_ready returns the FSM to IDLE; results stay readable until the next start clears them.
  - start is ignored.
- Width rules:
  - sum_abs_err cannot overflow: max d is 2^(BIT_WIDTH+1)-1, times 2^WINDOW_LOG2.
  - err_count reaches at most 2^WINDOW_LOG2, hence WINDOW_LOG2+1 bits.
- Simultaneous events: start together with res_ready in DONE is ignored; a new start is needed in IDLE.
- Reset mid-operation: returns to IDLE immediately and discards all partial results and pipeline contents.
- Combinational paths: none from inputs to outputs, except in_ready, which is purely a function of state.

Test Plan:
- Exact adder (ax_out=a+b), WINDOW_LOG2=2, samples (3,4),(255,255),(0,0),(128,1) -> res_valid after last accept+2 edges; sum_abs_err=0, max_abs_err=0, err_count=0.
- WINDOW_LOG2=2, mixed errors:
  - a=0x1F,b=0x01,ax=0x01F (loa K=5), error 1.
  - a=0xFF,b=0xFF,ax=0x1C0 (trunc0 K=5), error 62, applied twice.
  - a=0,b=0,ax=0x01F (trunc1 K=5), error 31.
  - Expected: sum_abs_err=156, max_abs_err=62, err_count=4.
- Upstream stall: in_valid low for 3 cycles between every sample -> identical results; in_ready falls the cycle after the 4th accept; busy stays high through DRAIN.
- Result backpressure: hold res_ready=0 for 10 cycles in DONE -> outputs stable, res_valid high, start pulses ignored, in_ready=0; res_ready=1 -> IDLE next cycle.
- Reset after 2 accepted samples in RUN -> all outputs 0 and state IDLE immediately; a new start+4 exact samples yields zero stats.
- Max-magnitude, WINDOW_LOG2=2, BIT_WIDTH=8: four samples a=0xFF,b=0xFF,ax=0 -> sum_abs_err=2040 (0x7F8), max_abs_err=510, err_count=4, no overflow.

Source files
------------

// File: rtl/ax_err_monitor_if.sv
// Sample/result handshake bundle for ax_err_monitor.
// The slave modport is the monitor. The master modport is the sample source and result consumer.
interface ax_err_monitor_if #(
  parameter int BIT_WIDTH   = 8,
  parameter int WINDOW_LOG2 = 8
);
  logic                           start;
  logic                           in_valid;
  logic                           in_ready;
  logic [BIT_WIDTH-1:0]           a;
  logic [BIT_WIDTH-1:0]           b;
  logic [BIT_WIDTH:0]             ax_out;
  logic                           res_valid;
  logic                           res_ready;
  logic [BIT_WIDTH+WINDOW_LOG2:0] sum_abs_err;
  logic [BIT_WIDTH:0]             max_abs_err;
  logic [WINDOW_LOG2:0]           err_count;
  logic                           busy;

  modport slave (
    input  start, in_valid, a, b, ax_out, res_ready,
    output in_ready, res_valid, sum_abs_err, max_abs_err, err_count, busy
  );

  modport master (
    output start, in_valid, a, b, ax_out, res_ready,
    input  in_ready, res_valid, sum_abs_err, max_abs_err, err_count, busy
  );
endinterface

// File: rtl/ax_err_monitor.sv
// Windowed error statistics for an approximate adder.
// The monitor recomputes the exact sum and accumulates |exact - ax_out| over 2^WINDOW_LOG2 samples.
module ax_err_monitor #(
  parameter int BIT_WIDTH   = 8,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  ax_err_monitor_if.slave    bus
);

  localparam int DW = BIT_WIDTH + 1;
  localparam int SW = DW + WINDOW_LOG2;
  localparam int CW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'((32'd1 << WINDOW_LOG2) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic            accept_s;
  logic            clear_s;
  logic [CW-1:0]   cnt_r;
  logic            v1_r;
  logic [DW-1:0]   exact1_r;
  logic [DW-1:0]   ax1_r;
  logic            v2_r;
  logic [DW-1:0]   d2_r;
  logic [SW-1:0]   sum_r;
  logic [DW-1:0]   max_r;
  logic [CW-1:0]   errc_r;
  logic            in_ready_r;
  logic            res_valid_r;
  logic            busy_r;

  // ax may exceed the exact sum for some adders, so take the magnitude.
  function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] x, input logic [DW-1:0] y);
    if (x >= y) begin
      abs_diff = x - y;
    end else begin
      abs_diff = y - x;
    end
  endfunction

  // Next-state decode, sample acceptance and window clear
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          clear_s      = 1'b1;
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        accept_s = bus.in_valid;
        if (bus.in_valid && (cnt_r == LAST_IDX)) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = RUN;
        end
      end
      DRAIN: begin
        // The last sample is in stage 2 with stage 1 empty, so it is accumulated on this edge.
        if (v2_r && !v1_r) begin
          next_state_s = DONE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Status outputs, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (next_state_s == RUN);
      res_valid_r <= (next_state_s == DONE);
      busy_r      <= (next_state_s == RUN) || (next_state_s == DRAIN);
    end
  end

  // Accepted-sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Stage 1 holds the exact sum. Stage 2 holds the absolute error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r     <= 1'b0;
      exact1_r <= {DW{1'b0}};
      ax1_r    <= {DW{1'b0}};
      v2_r     <= 1'b0;
      d2_r     <= {DW{1'b0}};
    end else begin
      v1_r <= accept_s;
      v2_r <= v1_r;
      if (accept_s) begin
        exact1_r <= {1'b0, bus.a} + {1'b0, bus.b};
        ax1_r    <= bus.ax_out;
      end else begin
        exact1_r <= exact1_r;
        ax1_r    <= ax1_r;
      end
      if (v1_r) begin
        d2_r <= abs_diff(exact1_r, ax1_r);
      end else begin
        d2_r <= d2_r;
      end
    end
  end

  // Statistics accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= {SW{1'b0}};
      max_r  <= {DW{1'b0}};
      errc_r <= {CW{1'b0}};
    end else if (clear_s) begin
      sum_r  <= {SW{1'b0}};
      max_r  <= {DW{1'b0}};
      errc_r <= {CW{1'b0}};
    end else if (v2_r) begin
      sum_r <= sum_r + {{WINDOW_LOG2{1'b0}}, d2_r};
      if (d2_r > max_r) begin
        max_r <= d2_r;
      end else begin
        max_r <= max_r;
      end
      if (d2_r != {DW{1'b0}}) begin
        errc_r <= errc_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        errc_r <= errc_r;
      end
    end else begin
      sum_r  <= sum_r;
      max_r  <= max_r;
      errc_r <= errc_r;
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.busy        = busy_r;
  assign bus.sum_abs_err = sum_r;
  assign bus.max_abs_err = max_r;
  assign bus.err_count   = errc_r;

endmodule

// File: tb/tb_ax_err_monitor.sv
// Directed bench for ax_err_monitor with BIT_WIDTH=8 and WINDOW_LOG2=2.
// Expected statistics are computed by hand for each window.
module tb_ax_err_monitor;
  localparam int BW = 8;
  localparam int WL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] sa [4];
  logic [7:0] sb [4];
  logic [8:0] sx [4];

  ax_err_monitor_if #(.BIT_WIDTH(BW), .WINDOW_LOG2(WL)) bus ();

  ax_err_monitor #(.BIT_WIDTH(BW), .WINDOW_LOG2(WL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [7:0] va, input logic [7:0] vb, input logic [8:0] vx);
    sa[i] = va;
    sb[i] = vb;
    sx[i] = vx;
  endtask

  task automatic chk_res(input string tag, input int es, input int em, input int ec);
    chk({tag, "_sum"}, 32'(bus.sum_abs_err), 32'(es));
    chk({tag, "_max"}, 32'(bus.max_abs_err), 32'(em));
    chk({tag, "_cnt"}, 32'(bus.err_count), 32'(ec));
  endtask

  // Runs one window of sa/sb/sx with `gap` idle cycles between samples and stops in DONE.
  task automatic run_window(input string tag, input int gap, input int es, input int em, input int ec);
    int k;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_rdy_run"}, 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = sa[i];
      bus.b        = sb[i];
      bus.ax_out   = sx[i];
      tick();
      bus.in_valid = 1'b0;
      if (i < 3) begin
        repeat (gap) tick();
      end
    end
    chk({tag, "_rdy_drain"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_busy_drain"}, 32'(bus.busy), 32'd1);
    tick();
    chk({tag, "_rv_t1"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_busy_t1"}, 32'(bus.busy), 32'd1);
    tick();
    chk({tag, "_rv_t2"}, 32'(bus.res_valid), 32'd1);
    k = 0;
    while (!bus.res_valid && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    chk_res(tag, es, em, ec);
  endtask

  task automatic handshake(input string tag);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_rv_idle"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rdy_idle"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic load_mixed();
    set_vec(0, 8'h1F, 8'h01, 9'h01F);
    set_vec(1, 8'hFF, 8'hFF, 9'h1C0);
    set_vec(2, 8'hFF, 8'hFF, 9'h1C0);
    set_vec(3, 8'h00, 8'h00, 9'h01F);
  endtask

  task automatic load_exact();
    set_vec(0, 8'd3,   8'd4,   9'd7);
    set_vec(1, 8'd255, 8'd255, 9'd510);
    set_vec(2, 8'd0,   8'd0,   9'd0);
    set_vec(3, 8'd128, 8'd1,   9'd129);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 8'd0;
    bus.b         = 8'd0;
    bus.ax_out    = 9'd0;
    bus.res_ready = 1'b0;
    repeat (2) tick();

    chk("rst_rdy", 32'(bus.in_ready), 32'd0);
    chk("rst_rv", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk_res("rst", 0, 0, 0);
    rst_n = 1'b1;
    tick();

    load_exact();
    run_window("exact", 0, 0, 0, 0);
    handshake("exact");

    load_mixed();
    run_window("mixed", 0, 156, 62, 4);
    handshake("mixed");
    chk_res("mixed_hold", 156, 62, 4);

    // Upstream stalls, then backpressure with start pulses that must be ignored
    run_window("stall", 3, 156, 62, 4);
    for (int j = 0; j < 10; j++) begin
      bus.start = (j % 3 == 0) ? 1'b1 : 1'b0;
      tick();
      chk("bp_rv", 32'(bus.res_valid), 32'd1);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
      chk_res("bp", 156, 62, 4);
    end
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
    chk("bp_rv_idle", 32'(bus.res_valid), 32'd0);
    tick();
    chk("bp_start_ignored_busy", 32'(bus.busy), 32'd0);
    chk("bp_start_ignored_rdy", 32'(bus.in_ready), 32'd0);

    // Reset after two accepted samples
    load_mixed();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = sa[i];
      bus.b        = sb[i];
      bus.ax_out   = sx[i];
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("mid_sum_pre", 32'(bus.sum_abs_err), 32'd1);
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rdy", 32'(bus.in_ready), 32'd0);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_rv", 32'(bus.res_valid), 32'd0);
    chk_res("mid", 0, 0, 0);
    #2;
    rst_n = 1'b1;
    tick();
    load_exact();
    run_window("post_rst", 0, 0, 0, 0);
    handshake("post_rst");

    for (int i = 0; i < 4; i++) set_vec(i, 8'hFF, 8'hFF, 9'h000);
    run_window("maxmag", 0, 2040, 510, 4);
    handshake("maxmag");
    chk("maxmag_hold_sum", 32'(bus.sum_abs_err), 32'd2040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
